// File: rtl/bicubic_pkg.sv
// Shared types, constants and the result clamp for the bicubic row-direction line sequencer.
package bicubic_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PRIME   = 3'd1,
        ISSUE   = 3'd2,
        ADVANCE = 3'd3,
        DRAIN   = 3'd4
    } state_t;

    localparam int PHASES        = 4;
    localparam int FRAC_BITS     = 7;
    localparam int ROUND_CONST   = 64;
    localparam int PIX_MAX       = 255;
    localparam int SUM_W_DEFAULT = 17;

    // Saturate a rounded, already-shifted sum into the 8-bit pixel range
    function automatic logic [7:0] clamp_pix(input logic signed [31:0] r);
        logic [7:0] res;
        if (r < 32'sd0) begin
            res = 8'd0;
        end else if (r > PIX_MAX) begin
            res = 8'd255;
        end else begin
            res = r[7:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/bicubic_out_fifo.sv
// Small synchronous FIFO holding {last, pixel} results; simultaneous write and read keep the count.
module bicubic_out_fifo
#(
    parameter int DEPTH = 4,
    parameter int W     = 9,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wptr_r;
    logic [AW-1:0] rptr_r;
    logic [CW-1:0] count_r;
    logic          do_wr_s;
    logic          do_rd_s;

    // A write into a full FIFO is only honoured when a read frees a slot in the same cycle
    always_comb begin
        do_rd_s = rd_en && (count_r != {CW{1'b0}});
        do_wr_s = wr_en && ((count_r != CW'(DEPTH)) || do_rd_s);
    end

    // Storage array
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem_r[wptr_r] <= wr_data;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_r  <= {AW{1'b0}};
            rptr_r  <= {AW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (do_wr_s) begin
                wptr_r <= wptr_r + AW'(1);
            end
            if (do_rd_s) begin
                rptr_r <= rptr_r + AW'(1);
            end
            case ({do_wr_s, do_rd_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rd_data = mem_r[rptr_r];
    assign empty   = (count_r == {CW{1'b0}});
    assign count   = count_r;

endmodule

// File: rtl/bicubic_line_sequencer.sv
// Sequences one row of bicubic x4 upscaling: sliding 4-pixel window with edge replication,
// four phase issues per pixel to the external weight unit, round/clamp, and a credited output FIFO.
module bicubic_line_sequencer
    import bicubic_pkg::*;
#(
    parameter int SUM_W      = SUM_W_DEFAULT,
    parameter int FIFO_DEPTH = 4
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              in_pixel,
    input  logic                    in_last,
    output logic [7:0]              tap_0,
    output logic [7:0]              tap_1,
    output logic [7:0]              tap_2,
    output logic [7:0]              tap_3,
    output logic [1:0]              tap_phase,
    input  logic signed [SUM_W-1:0] weight_sum,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              out_pixel,
    output logic                    out_last
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t               state_r;
    logic [3:0][7:0]      w_r;
    logic                 pcnt_r;
    logic [1:0]           lidx_r;
    logic                 last_seen_r;
    logic [1:0]           phase_r;
    logic [3:0][7:0]      tap_r;
    logic [1:0]           tap_phase_r;
    logic                 v1_r;
    logic                 v1_last_r;
    logic                 v2_r;
    logic                 v2_last_r;

    logic                 in_ready_s;
    logic                 accept_s;
    logic [CNT_W-1:0]     fifo_count_s;
    logic [CNT_W:0]       inflight_s;
    logic                 credit_s;
    logic                 issue_s;
    logic                 last_tag_s;
    logic signed [SUM_W:0] rnd_s;
    logic signed [SUM_W:0] r_s;
    logic [7:0]           pix_s;
    logic [8:0]           head_s;
    logic                 fifo_empty_s;
    logic                 out_fire_s;

    // Input acceptance depends only on the registered state
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            IDLE, PRIME: in_ready_s = 1'b1;
            ADVANCE:     in_ready_s = !last_seen_r;
            default:     in_ready_s = 1'b0;
        endcase
    end

    assign accept_s   = in_valid && in_ready_s;
    // Everything already issued but not yet drained must fit in the FIFO
    assign inflight_s = {1'b0, fifo_count_s} + (CNT_W+1)'(v1_r) + (CNT_W+1)'(v2_r);
    assign credit_s   = inflight_s < (CNT_W+1)'(FIFO_DEPTH);
    assign issue_s    = (state_r == ISSUE) && credit_s;
    assign last_tag_s = last_seen_r && (lidx_r == 2'd1) && (phase_r == 2'(PHASES-1));

    // Window sequencing FSM, tap register and issue-valid pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            w_r         <= {4{8'd0}};
            pcnt_r      <= 1'b0;
            lidx_r      <= 2'd0;
            last_seen_r <= 1'b0;
            phase_r     <= 2'd0;
            tap_r       <= {4{8'd0}};
            tap_phase_r <= 2'd0;
            v1_r        <= 1'b0;
            v1_last_r   <= 1'b0;
            v2_r        <= 1'b0;
            v2_last_r   <= 1'b0;
        end else begin
            v2_r      <= v1_r;
            v2_last_r <= v1_last_r;
            if (issue_s) begin
                tap_r       <= w_r;
                tap_phase_r <= phase_r;
                v1_r        <= 1'b1;
                v1_last_r   <= last_tag_s;
            end else begin
                v1_r      <= 1'b0;
                v1_last_r <= 1'b0;
            end

            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        w_r     <= {4{in_pixel}};
                        pcnt_r  <= 1'b0;
                        phase_r <= 2'd0;
                        if (in_last) begin
                            lidx_r      <= 2'd1;
                            last_seen_r <= 1'b1;
                            state_r     <= ISSUE;
                        end else begin
                            state_r <= PRIME;
                        end
                    end
                end
                PRIME: begin
                    if (accept_s) begin
                        if (!pcnt_r) begin
                            w_r[2] <= in_pixel;
                            w_r[3] <= in_pixel;
                            if (in_last) begin
                                lidx_r      <= 2'd2;
                                last_seen_r <= 1'b1;
                                state_r     <= ISSUE;
                            end else begin
                                pcnt_r <= 1'b1;
                            end
                        end else begin
                            w_r[3] <= in_pixel;
                            if (in_last) begin
                                lidx_r      <= 2'd3;
                                last_seen_r <= 1'b1;
                            end
                            state_r <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (issue_s) begin
                        phase_r <= phase_r + 2'd1;
                        if (phase_r == 2'(PHASES-1)) begin
                            state_r <= last_tag_s ? DRAIN : ADVANCE;
                        end
                    end
                end
                ADVANCE: begin
                    // After the last pixel the window shifts in replicas of p[N-1]
                    if (last_seen_r) begin
                        w_r     <= {w_r[3], w_r[3], w_r[2], w_r[1]};
                        lidx_r  <= lidx_r - 2'd1;
                        state_r <= ISSUE;
                    end else if (accept_s) begin
                        w_r <= {in_pixel, w_r[3], w_r[2], w_r[1]};
                        if (in_last) begin
                            last_seen_r <= 1'b1;
                            lidx_r      <= 2'd3;
                        end
                        state_r <= ISSUE;
                    end
                end
                DRAIN: begin
                    if (out_fire_s && head_s[8]) begin
                        last_seen_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // Round half-up in SUM_W+1 bits, then arithmetic shift out the fraction
    assign rnd_s = $signed({weight_sum[SUM_W-1], weight_sum}) + $signed((SUM_W+1)'(ROUND_CONST));
    assign r_s   = rnd_s >>> FRAC_BITS;
    assign pix_s = clamp_pix({{(31-SUM_W){r_s[SUM_W]}}, r_s});

    assign out_fire_s = out_valid && out_ready;

    bicubic_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (9)
    ) u_out_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (v2_r),
        .wr_data ({v2_last_r, pix_s}),
        .rd_en   (out_fire_s),
        .rd_data (head_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    // Outputs read zero for the whole reset cycle, not just after the edge
    assign in_ready  = in_ready_s && !rst;
    assign tap_0     = rst ? 8'd0 : tap_r[0];
    assign tap_1     = rst ? 8'd0 : tap_r[1];
    assign tap_2     = rst ? 8'd0 : tap_r[2];
    assign tap_3     = rst ? 8'd0 : tap_r[3];
    assign tap_phase = rst ? 2'd0 : tap_phase_r;
    assign out_valid = !fifo_empty_s && !rst;
    assign out_pixel = rst ? 8'd0 : head_s[7:0];
    assign out_last  = rst ? 1'b0 : head_s[8];

endmodule

// File: tb/tb_bicubic_line_sequencer.sv
// Self-checking bench: behavioural x4 bicubic line model plus a bench-side weight unit.
module tb_bicubic_line_sequencer;

    localparam int SUM_W = 17;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic [7:0]              in_pixel;
    logic                    in_last;
    logic [7:0]              tap_0, tap_1, tap_2, tap_3;
    logic [1:0]              tap_phase;
    logic signed [SUM_W-1:0] weight_sum;
    logic                    out_valid;
    logic                    out_ready;
    logic [7:0]              out_pixel;
    logic                    out_last;

    always #5 clk = ~clk;

    bicubic_line_sequencer #(.SUM_W(SUM_W), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
        .in_last(in_last), .tap_0(tap_0), .tap_1(tap_1), .tap_2(tap_2), .tap_3(tap_3),
        .tap_phase(tap_phase), .weight_sum(weight_sum), .out_valid(out_valid),
        .out_ready(out_ready), .out_pixel(out_pixel), .out_last(out_last)
    );

    int checks = 0;
    int errors = 0;

    int          pix_a [64];
    logic [33:0] exp_iss_q [$];
    logic [8:0]  exp_res_q [$];
    logic [33:0] iss_log [128];
    logic [8:0]  res_log [128];
    int          iss_cnt, res_cnt, got_line;
    int          iss_total, acc_total;

    function automatic int wt(input int ph, input int i);
        int t [4];
        case (ph)
            0:       t = '{0, 128, 0, 0};
            1:       t = '{-9, 111, 29, -3};
            2:       t = '{-8, 72, 72, -8};
            default: t = '{-3, 29, 111, -9};
        endcase
        return t[i];
    endfunction

    function automatic int wsum(input int a, input int b, input int c, input int d, input int ph);
        return wt(ph, 0) * a + wt(ph, 1) * b + wt(ph, 2) * c + wt(ph, 3) * d;
    endfunction

    function automatic int model_pix(input int a, input int b, input int c, input int d, input int ph);
        int r;
        r = (wsum(a, b, c, d, ph) + 64) >>> 7;
        if (r < 0) r = 0;
        if (r > 255) r = 255;
        return r;
    endfunction

    function automatic int pix_at(input int i, input int n);
        int j;
        j = i;
        if (j < 0) j = 0;
        if (j > n - 1) j = n - 1;
        return pix_a[j];
    endfunction

    // Bench-side weight unit: captures taps each edge, sum is ready one cycle later
    logic [7:0] wu_t0, wu_t1, wu_t2, wu_t3;
    logic [1:0] wu_ph;
    always @(posedge clk) begin
        wu_t0 <= tap_0; wu_t1 <= tap_1; wu_t2 <= tap_2; wu_t3 <= tap_3; wu_ph <= tap_phase;
    end
    assign weight_sum = SUM_W'(wsum(int'(wu_t0), int'(wu_t1), int'(wu_t2), int'(wu_t3), int'(wu_ph)));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic load_model(input int n);
        int t0, t1, t2, t3;
        for (int k = 0; k < n; k++) begin
            t0 = pix_at(k - 1, n); t1 = pix_at(k, n); t2 = pix_at(k + 1, n); t3 = pix_at(k + 2, n);
            for (int ph = 0; ph < 4; ph++) begin
                exp_iss_q.push_back({2'(ph), 8'(t0), 8'(t1), 8'(t2), 8'(t3)});
                exp_res_q.push_back({(k == n - 1) && (ph == 3), 8'(model_pix(t0, t1, t2, t3, ph))});
            end
        end
    endtask

    logic [33:0] cur_t, prev_t;
    logic        stall_prev;
    logic [8:0]  prev_out;
    assign cur_t = {tap_phase, tap_0, tap_1, tap_2, tap_3};

    // Compare process: issues, results, hold-stability, credit limit and reset values
    always @(negedge clk) begin
        if (rst) begin
            chk("reset_ctrl_outputs", {in_ready, out_valid, out_last, tap_phase, out_pixel}, 64'd0);
            chk("reset_tap_outputs", {tap_0, tap_1, tap_2, tap_3}, 64'd0);
            prev_t = cur_t; stall_prev = 1'b0; iss_total = 0; acc_total = 0;
        end else begin
            if (cur_t != prev_t) begin
                if (exp_iss_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_issue actual=%0h required=none", cur_t);
                end else begin
                    chk("issue_taps", cur_t, exp_iss_q.pop_front());
                end
                if (iss_cnt < 128) iss_log[iss_cnt] = cur_t;
                iss_cnt++; iss_total++;
            end
            prev_t = cur_t;
            checks++;
            if (iss_total - acc_total > 4) begin
                errors++;
                $display("FAIL outstanding_limit actual=%0d required<=4", iss_total - acc_total);
            end
            if (stall_prev) chk("hold_stable", {out_valid, out_last, out_pixel}, {1'b1, prev_out});
            if (out_valid && out_ready) begin
                if (exp_res_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_result actual=%0d last=%0d required=none", out_pixel, out_last);
                end else begin
                    chk("result", {out_last, out_pixel}, exp_res_q.pop_front());
                end
                if (res_cnt < 128) res_log[res_cnt] = {out_last, out_pixel};
                res_cnt++; got_line++; acc_total++;
            end
            stall_prev = out_valid && !out_ready;
            prev_out   = {out_last, out_pixel};
        end
    end

    task automatic drive_in(input int idx, input int n, input int vprob);
        in_valid = (idx < n) && ($urandom_range(0, 99) < vprob);
        in_pixel = (idx < n) ? 8'(pix_a[idx]) : 8'd0;
        in_last  = (idx == n - 1);
    endtask

    task automatic run_line(input int n, input int vprob, input int rprob,
                            input int stall_at, input int rst_at, output int cyc);
        int idx, stall_left, total;
        bit acc, stall_started, stall_chk;
        idx = 0; cyc = 0; stall_left = 0; stall_started = 0; stall_chk = 0; total = 4 * n;
        got_line = 0; iss_cnt = 0; res_cnt = 0;
        load_model(n);
        drive_in(idx, n, vprob);
        out_ready = ($urandom_range(0, 99) < rprob);
        while (got_line < total && cyc < 3000) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            if (stall_started && !stall_chk && stall_left == 0) begin
                chk("stall_in_ready", in_ready, 64'd0);
                chk("stall_out_valid", out_valid, 64'd1);
                stall_chk = 1;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) idx++;
            if (rst_at >= 0 && got_line >= rst_at) begin
                rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
                exp_res_q.delete(); exp_iss_q.delete();
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
            drive_in(idx, n, vprob);
            if (!stall_started && stall_at >= 0 && got_line >= stall_at) begin
                stall_started = 1; stall_left = 10;
            end
            if (stall_left > 0) begin
                out_ready = 1'b0; stall_left--;
            end else begin
                out_ready = ($urandom_range(0, 99) < rprob);
            end
        end
        if (got_line < total) begin
            checks++; errors++;
            $display("FAIL line_timeout actual=%0d results required=%0d", got_line, total);
        end
        chk("issue_queue_drained", exp_iss_q.size(), 64'd0);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    initial begin
        int cyc;
        int n;
        rst = 1'b1; in_valid = 1'b0; in_pixel = 8'd0; in_last = 1'b0; out_ready = 1'b0;
        iss_cnt = 0; res_cnt = 0; got_line = 0; iss_total = 0; acc_total = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Hand-computed pins on the model itself
        chk("model_clamp_lo", model_pix(255, 0, 0, 255, 3), 64'd0);
        chk("model_clamp_hi", model_pix(0, 255, 255, 0, 3), 64'd255);
        chk("model_const", model_pix(100, 100, 100, 100, 1), 64'd100);

        // Flat line of 100s
        for (int i = 0; i < 4; i++) pix_a[i] = 100;
        run_line(4, 100, 100, -1, -1, cyc);
        chk("flat_count", res_cnt, 64'd16);
        chk("flat_16th", res_log[15], 64'h164);
        chk("flat_15th", res_log[14], 64'h064);

        // Single pixel line
        pix_a[0] = 37;
        run_line(1, 100, 100, -1, -1, cyc);
        chk("single_issues", iss_cnt, 64'd4);
        chk("single_issue3", iss_log[3], {2'd3, 8'd37, 8'd37, 8'd37, 8'd37});
        chk("single_last", res_log[3], {1'b1, 8'd37});

        // Ramp: window contents at the edges
        pix_a[0] = 0; pix_a[1] = 10; pix_a[2] = 20; pix_a[3] = 30;
        run_line(4, 100, 100, -1, -1, cyc);
        chk("ramp_issues", iss_cnt, 64'd16);
        chk("ramp_k0", iss_log[0], {2'd0, 8'd0, 8'd0, 8'd10, 8'd20});
        chk("ramp_k3", iss_log[12], {2'd0, 8'd20, 8'd30, 8'd30, 8'd30});
        for (int i = 0; i < 16; i++) chk("ramp_phase", iss_log[i][33:32], 64'(i % 4));

        // Clamp at both rails
        pix_a[0] = 255; pix_a[1] = 0; pix_a[2] = 0; pix_a[3] = 255;
        run_line(4, 100, 100, -1, -1, cyc);
        chk("clamp_low_k1p3", res_log[7], 64'd0);
        pix_a[0] = 0; pix_a[1] = 255; pix_a[2] = 255; pix_a[3] = 0;
        run_line(4, 100, 100, -1, -1, cyc);
        chk("clamp_high_k1p3", res_log[7], 64'd255);

        // Backpressure mid-line
        for (int i = 0; i < 8; i++) pix_a[i] = $urandom_range(1, 255);
        run_line(8, 100, 100, 8, -1, cyc);
        chk("bp_count", res_cnt, 64'd32);

        // Reset mid-line, then the flat line again
        pix_a[0] = 50; pix_a[1] = 60; pix_a[2] = 70; pix_a[3] = 80;
        run_line(4, 100, 100, -1, 2, cyc);
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) pix_a[i] = 100;
        run_line(4, 100, 100, -1, -1, cyc);
        chk("post_reset_count", res_cnt, 64'd16);
        chk("post_reset_16th", res_log[15], 64'h164);

        // Steady-state throughput: 4 results per 5 cycles
        for (int i = 0; i < 16; i++) pix_a[i] = $urandom_range(1, 255);
        run_line(16, 100, 100, -1, -1, cyc);
        checks++;
        if (cyc > 5 * 16 + 8) begin
            errors++;
            $display("FAIL throughput actual=%0d cycles required<=%0d", cyc, 5 * 16 + 8);
        end

        // Randomized lines with input gaps and output backpressure
        for (int l = 0; l < 10; l++) begin
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) pix_a[i] = $urandom_range(1, 255);
            run_line(n, 80, 70, -1, -1, cyc);
            chk("rand_count", res_cnt, 64'(4 * n));
        end

        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bicubic_line_sequencer.md
# bicubic_line_sequencer

Sequences one row-direction bicubic x4 upscale pass through the shared 4-tap weight unit. Accepts a pixel stream one line at a time, keeps a 4-pixel sliding window with edge replication, and issues each window four times (phases 0..3) to the weight unit. Rounds and clamps each returned weighted sum to 8 bits, then delivers the results downstream on a valid/ready stream. Sits between the line reader and the output writer; the weight unit is instantiated beside it at top level.

## Interface
- SUM_W, 17: width of the two's-complement weighted sum returned by the weight unit (the sum range is -3060..35700).
- FIFO_DEPTH, 4: output buffer entries; fixed at 4 for this revision.

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input pixel valid
- in_ready  out  1  input pixel accepted when in_valid && in_ready
- in_pixel  in  8  unsigned input pixel
- in_last  in  1  marks the final pixel of a line
- tap_0..tap_3  out  8 each  window pixels p[k-1], p[k], p[k+1], p[k+2] driven to the weight unit
- tap_phase  out  2  phase select for the weight unit
- weight_sum  in  SUM_W  signed sum, valid one cycle after the taps are captured by the unit
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_pixel  out  8  interpolated pixel
- out_last  out  1  final result of a line

## Operation
- Window w0..w3; w1 is the centre pixel p[k]. Indices are clamped to [0, N-1] by replication.
- lidx (2 bits) is the window index holding p[N-1]; it is valid once last_seen is set.
- **IDLE**: in_ready=1. On accept of pixel a: w <= {a,a,a,a}.
  - If in_last: lidx <= 1 and go to ISSUE.
  - Otherwise go to PRIME with pcnt=0.
- **PRIME**: in_ready=1.
  - pcnt=0, accept b: w <= {w0,w0,b,b}. If in_last: lidx <= 2 and go to ISSUE. Otherwise pcnt <= 1.
  - pcnt=1, accept c: w3 <= c. If in_last: lidx <= 3. Go to ISSUE.
- **ISSUE**: issues phases 0,1,2,3 in order, one per cycle, only when a credit is available (see Timing). After phase 3: go to DRAIN if last_seen && lidx==1, otherwise go to ADVANCE.
- **ADVANCE**:
  - If !last_seen: in_ready=1. Wait for a pixel d, then w <= {w1,w2,w3,d}. If in_last, set last_seen and lidx <= 3.
  - If last_seen: in_ready=0. w <= {w1,w2,w3,w3} and lidx <= lidx-1.
  - In both cases go to ISSUE.
- **DRAIN**: in_ready=0. Go to IDLE once the out_last result has been accepted downstream. Clear last_seen.
- The issue carrying phase 3 with last_seen && lidx==1 is tagged last. The tag travels with the result to out_last.
- A line of N pixels produces exactly 4N results.
- Result arithmetic:
  - r = (weight_sum + 64) >>> 7, computed in SUM_W+1 bits signed.
  - out_pixel = 0 if r<0, 255 if r>255, r otherwise.
  - Each phase's weights sum to 128, so a constant input reproduces itself.

## Timing
- Reset state: state=IDLE, last_seen=0, FIFO empty, pipeline valid bits 0. All outputs are 0 while rst=1, including in_ready.
- Taps and tap_phase are registered, updated at edge E0 of the issue.
  - The weight unit captures them at E1.
  - weight_sum is sampled at E2 and written into the FIFO.
  - out_valid rises after E2: 2-cycle issue-to-output latency.
- Credit rule: an issue is allowed only if fifo_count + v1 + v2 < FIFO_DEPTH.
  - v1 = taps in the tap register, v2 = taps inside the weight unit.
  - When no issue occurs, the taps hold their value and v1 <= 0. The weight unit has no enable, so invalid slots are discarded by valid tracking.
- Throughput with out_ready held high: 4 results per 5 cycles in steady state (ADVANCE costs 1 cycle).
- out_valid/out_pixel/out_last come from the FIFO head. They must hold stable while out_valid && !out_ready.
- A FIFO write and read in the same cycle are both honoured; the count is unchanged.
- rst mid-line flushes everything: the pending line is abandoned and no out_last is produced for it.

## Structure
- Package bicubic_pkg holds:
  - the state enum (IDLE, PRIME, ISSUE, ADVANCE, DRAIN)
  - PHASES=4, FRAC_BITS=7, ROUND_CONST=64, PIX_MAX=255
  - the default SUM_W
- Sub-module bicubic_out_fifo: synchronous FIFO, 9-bit entries {last, pixel}, depth 4, with a count output.
- The weight unit is not instantiated here. It is connected at top level.

## Test plan
- Bench weight model for phase 3 is (-3, 29, 111, -9); the other phases use any weights summing to 128.
- Line 100,100,100,100, out_ready=1 -> 16 results all 100; out_last only on the 16th.
- Single pixel 37 with in_last -> 4 issues with taps (37,37,37,37) and phases 0..3 -> 4 results of 37, last on the 4th.
- Ramp 0,10,20,30:
  - k=0 taps = (0,0,10,20)
  - k=3 taps = (20,30,30,30)
  - exactly 16 issues; phase sequence 0,1,2,3 per k
- Clamp, checking the phase-3 result at k=1:
  - line 255,0,0,255: window (255,0,0,255), sum -3060 -> 0
  - line 0,255,255,0: window (0,255,255,0), sum 35700 -> 255
- Backpressure: out_ready=0 for 10 cycles mid-line.
  - Issues stop once count+inflight reaches 4; in_ready stays 0.
  - No result is lost or duplicated; ordering and out_last are correct after release.
- Reset mid-line: rst for 1 cycle after 2 results of a 4-pixel line.
  - All outputs read 0 during reset; no out_last.
  - A following line of 100s behaves exactly like the first scenario.
